// File: rtl/ibex_rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// The LSU bypass path is enabled by defining RF_ARB_BYPASS_EN.
package ibex_rf_arb_pkg;

  typedef enum logic {
    WB_SRC_ID  = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef enum logic {
    ARB_NORMAL    = 1'b0,
    ARB_FORCE_LSU = 1'b1
  } rf_arb_state_e;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_t;

  // Wide enough for the largest starvation limit (15).
  localparam int unsigned StarveW = 4;

  // x0 never aliases anything: writes to it are discarded by the RF.
  function automatic logic addr_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/ibex_rf_arb_fifo.sv
// Circular buffer of pending LSU writes, exposing every slot's valid bit and
// address so the arbiter can check hazards against all buffered loads.
module ibex_rf_arb_fifo
  import ibex_rf_arb_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  rf_wr_t                push_data_i,
  input  logic                  pop_i,
  output rf_wr_t                head_o,
  output logic [PtrW-1:0]       head_idx_o,
  output logic [CntW-1:0]       count_o,
  output logic [Depth-1:0]      ent_valid_o,
  output logic [Depth-1:0][4:0] ent_addr_o
);

  rf_wr_t            mem_q [Depth];
  rf_wr_t            mem_d [Depth];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   off;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      mem_d[wptr_q] = push_data_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop_i) rptr_d = rptr_q + PtrW'(1);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below the count;
  // pointer arithmetic wraps because Depth is a power of two.
  always_comb begin
    off = '0;
    for (int i = 0; i < Depth; i++) begin
      off            = PtrW'(i) - rptr_q;
      ent_valid_o[i] = {1'b0, off} < cnt_q;
      ent_addr_o[i]  = mem_q[i].waddr;
    end
  end

  assign head_o     = mem_q[rptr_q];
  assign head_idx_o = rptr_q;
  assign count_o    = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Shares the single RF write port between ID/EX results and LSU load data.
// Define RF_ARB_BYPASS_EN to let an idle-port LSU response skip the buffer.
module ibex_rf_wr_arbiter
  import ibex_rf_arb_pkg::*;
#(
  parameter int unsigned FifoDepth = 2,
  parameter int unsigned MaxStarve = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_we_i,
  input  logic [4:0]               id_waddr_i,
  input  logic [31:0]              id_wdata_i,
  output logic                     id_ready_o,
  input  logic                     lsu_valid_i,
  input  logic [4:0]               lsu_waddr_i,
  input  logic [31:0]              lsu_wdata_i,
  output logic                     lsu_ready_o,
  input  logic [4:0]               rs1_addr_i,
  input  logic [4:0]               rs2_addr_i,
  output logic                     hazard_o,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic                     rf_src_o,
  output logic [$clog2(FifoDepth):0] fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  rf_arb_state_e          state_q, state_d;
  logic [StarveW-1:0]     starve_q, starve_d;
  rf_wr_t                 head, push_data;
  logic [PtrW-1:0]        head_idx;
  logic [CntW-1:0]        count;
  logic [FifoDepth-1:0]   ent_valid;
  logic [FifoDepth-1:0][4:0] ent_addr;
  logic                   head_valid, push, pop, id_grant, waw, haz;
  wb_src_e                rf_src;
`ifdef RF_ARB_BYPASS_EN
  logic                   bypass;
`endif

  assign head_valid = (count != '0);

  // WAW looks at every live slot (the popping one included) so an ID write
  // can never land before an older load to the same register.
  always_comb begin
    waw = 1'b0;
    haz = 1'b0;
    for (int i = 0; i < FifoDepth; i++) begin
      if (ent_valid[i] && addr_hit(id_waddr_i, ent_addr[i])) waw = 1'b1;
      if (ent_valid[i] && !(pop && PtrW'(i) == head_idx) &&
          (addr_hit(rs1_addr_i, ent_addr[i]) || addr_hit(rs2_addr_i, ent_addr[i]) ||
           addr_hit(id_waddr_i, ent_addr[i])))
        haz = 1'b1;
    end
    waw = waw & id_we_i;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    id_grant = 1'b0;
    pop      = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    bypass   = 1'b0;
`endif
    if (!rst_i) begin
      unique case (state_q)
        ARB_NORMAL: begin
          if (id_we_i && !waw)  id_grant = 1'b1;
          else if (head_valid)  pop      = 1'b1;
`ifdef RF_ARB_BYPASS_EN
          else if (lsu_valid_i) bypass   = 1'b1;
`endif
        end
        ARB_FORCE_LSU: begin
          pop     = head_valid;
          state_d = ARB_NORMAL;
        end
        default: state_d = ARB_NORMAL;
      endcase

      if (pop)             starve_d = '0;
      else if (head_valid) starve_d = starve_q + StarveW'(1);
      else                 starve_d = '0;

      if (state_q == ARB_NORMAL && head_valid && !pop &&
          starve_d >= StarveW'(MaxStarve))
        state_d = ARB_FORCE_LSU;
    end
  end

  assign lsu_ready_o = !rst_i && ((count < CntW'(FifoDepth)) || pop);
`ifdef RF_ARB_BYPASS_EN
  assign push = lsu_valid_i && lsu_ready_o && !bypass;
`else
  assign push = lsu_valid_i && lsu_ready_o;
`endif
  assign push_data = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};

  // Write-port mux; x0 writes still take their slot but never enable the RF.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    rf_src     = WB_SRC_ID;
    if (id_grant) begin
      rf_we_o    = (id_waddr_i != 5'd0);
      rf_waddr_o = id_waddr_i;
      rf_wdata_o = id_wdata_i;
    end else if (pop) begin
      rf_we_o    = (head.waddr != 5'd0);
      rf_waddr_o = head.waddr;
      rf_wdata_o = head.wdata;
      rf_src     = WB_SRC_LSU;
    end
`ifdef RF_ARB_BYPASS_EN
    else if (bypass) begin
      rf_we_o    = (lsu_waddr_i != 5'd0);
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
      rf_src     = WB_SRC_LSU;
    end
`endif
  end

  assign rf_src_o     = rf_src;
  assign id_ready_o   = id_grant;
  assign hazard_o     = haz && !rst_i;
  assign fifo_count_o = rst_i ? '0 : count;

  ibex_rf_arb_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .head_idx_o  (head_idx),
    .count_o     (count),
    .ent_valid_o (ent_valid),
    .ent_addr_o  (ent_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Cycle-vector bench for ibex_rf_wr_arbiter (FifoDepth=2, MaxStarve=3).
module tb_ibex_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_i, id_we_i, lsu_valid_i;
  logic [4:0]  id_waddr_i, lsu_waddr_i, rs1_addr_i, rs2_addr_i;
  logic [31:0] id_wdata_i, lsu_wdata_i;
  logic        id_ready_o, lsu_ready_o, hazard_o, rf_we_o, rf_src_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [1:0]  fifo_count_o;

  always #5 clk = ~clk;

  ibex_rf_wr_arbiter #(.FifoDepth(2), .MaxStarve(3)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .id_we_i(id_we_i), .id_waddr_i(id_waddr_i), .id_wdata_i(id_wdata_i), .id_ready_o(id_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(lsu_ready_o), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .hazard_o(hazard_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rf_src_o(rf_src_o), .fifo_count_o(fifo_count_o)
  );

  typedef struct {
    logic rst, id_we; logic [4:0] id_a; logic [31:0] id_d;
    logic lv; logic [4:0] la; logic [31:0] ld; logic [4:0] rs1, rs2;
    logic e_we; logic [4:0] e_a; logic [31:0] e_d;
    logic e_src, e_idr, e_lr, e_hz; logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl [64];
  vec_t sb [$];
  int   n_vec = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic iw, input logic [4:0] ia, input logic [31:0] idd,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic we, input logic [4:0] a, input logic [31:0] d,
                     input logic src, input logic idr, input logic lr, input logic hz,
                     input logic [1:0] cnt);
    tbl[n_vec] = '{r, iw, ia, idd, lv, la, ld, r1, r2, we, a, d, src, idr, lr, hz, cnt};
    n_vec++;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst_i = 1'b1; id_we_i = 1'b0; id_waddr_i = '0; id_wdata_i = '0;
    lsu_valid_i = 1'b0; lsu_waddr_i = '0; lsu_wdata_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;

    // reset with both requesters active
    add(1, 1,5,32'h1111, 1,6,32'h2222, 0,0,  0,0,32'h0,0, 0,0,0,0);
    add(1, 1,5,32'h1111, 1,6,32'h2222, 0,0,  0,0,32'h0,0, 0,0,0,0);
    // ID and LSU collide: ID first, load one cycle later
    add(0, 1,5,32'h1111, 1,6,32'h2222, 0,0,  1,5,32'h1111,0, 1,1,0,0);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  1,6,32'h2222,1, 0,1,0,1);
    // starvation: x7 loses three times then is forced
    add(0, 1,1,32'hA1,   1,7,32'h77,   0,0,  1,1,32'hA1,0, 1,1,0,0);
    add(0, 1,2,32'hA2,   0,0,32'h0,    0,0,  1,2,32'hA2,0, 1,1,0,1);
    add(0, 1,3,32'hA3,   0,0,32'h0,    0,0,  1,3,32'hA3,0, 1,1,0,1);
    add(0, 1,4,32'hA4,   0,0,32'h0,    0,0,  1,4,32'hA4,0, 1,1,0,1);
    add(0, 1,5,32'hA5,   0,0,32'h0,    0,0,  1,7,32'h77,1, 0,1,0,1);
    add(0, 1,5,32'hA5,   0,0,32'h0,    0,0,  1,5,32'hA5,0, 1,1,0,0);
    // WAW on x9 buffered behind x8
    add(0, 1,1,32'hB1,   1,8,32'h88,   0,0,  1,1,32'hB1,0, 1,1,0,0);
    add(0, 1,2,32'hB2,   1,9,32'h99,   0,0,  1,2,32'hB2,0, 1,1,0,1);
    add(0, 1,9,32'hC9,   0,0,32'h0,    0,0,  1,8,32'h88,1, 0,1,1,2);
    add(0, 1,9,32'hC9,   0,0,32'h0,    0,0,  1,9,32'h99,1, 0,1,0,1);
    add(0, 1,9,32'hC9,   0,0,32'h0,    0,0,  1,9,32'hC9,0, 1,1,0,0);
    // RAW via rs1 / rs2
    add(0, 1,1,32'hD1,   1,10,32'hAA,  10,0, 1,1,32'hD1,0, 1,1,0,0);
    add(0, 1,2,32'hD2,   0,0,32'h0,    10,0, 1,2,32'hD2,0, 1,1,1,1);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,10, 1,10,32'hAA,1, 0,1,0,1);
    // fill, backpressure, simultaneous push/pop when full
    add(0, 1,1,32'hE1,   1,11,32'hB1,  0,0,  1,1,32'hE1,0, 1,1,0,0);
    add(0, 1,2,32'hE2,   1,12,32'hB2,  0,0,  1,2,32'hE2,0, 1,1,0,1);
    add(0, 1,3,32'hE3,   1,13,32'hB3,  0,0,  1,3,32'hE3,0, 1,0,0,2);
    add(0, 0,0,32'h0,    1,13,32'hB3,  0,0,  1,11,32'hB1,1, 0,1,0,2);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  1,12,32'hB2,1, 0,1,0,2);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  1,13,32'hB3,1, 0,1,0,1);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  0,0,32'h0,0,  0,1,0,0);
    // x0 load while idle, then x3
`ifdef RF_ARB_BYPASS_EN
    add(0, 0,0,32'h0,    1,0,32'hFFFF_FFFF, 0,0, 0,0,32'hFFFF_FFFF,1, 0,1,0,0);
    add(0, 0,0,32'h0,    1,3,32'h33,   0,0,  1,3,32'h33,1, 0,1,0,0);
`else
    add(0, 0,0,32'h0,    1,0,32'hFFFF_FFFF, 0,0, 0,0,32'h0,0, 0,1,0,0);
    add(0, 0,0,32'h0,    1,3,32'h33,   0,0,  0,0,32'hFFFF_FFFF,1, 0,1,0,1);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  1,3,32'h33,1, 0,1,0,1);
`endif
    // buffered x0 never hazards and never blocks an ID write to x0
    add(0, 1,1,32'hF1,   1,0,32'hFFFF_FFFF, 0,0, 1,1,32'hF1,0, 1,1,0,0);
    add(0, 1,0,32'hF0,   0,0,32'h0,    0,0,  0,0,32'hF0,0, 1,1,0,1);
    add(0, 0,0,32'h0,    0,0,32'h0,    0,0,  0,0,32'hFFFF_FFFF,1, 0,1,0,1);
    // reset mid-operation discards the buffered x4
    add(0, 1,1,32'hF1,   1,4,32'h44,   0,0,  1,1,32'hF1,0, 1,1,0,0);
    add(1, 1,2,32'hF2,   1,5,32'h55,   4,4,  0,0,32'h0,0, 0,0,0,0);
    add(0, 0,0,32'h0,    0,0,32'h0,    4,0,  0,0,32'h0,0, 0,1,0,0);

    for (int i = 0; i < n_vec; i++) begin
      @(posedge clk);
      #1;
      rst_i = tbl[i].rst; id_we_i = tbl[i].id_we; id_waddr_i = tbl[i].id_a; id_wdata_i = tbl[i].id_d;
      lsu_valid_i = tbl[i].lv; lsu_waddr_i = tbl[i].la; lsu_wdata_i = tbl[i].ld;
      rs1_addr_i = tbl[i].rs1; rs2_addr_i = tbl[i].rs2;
      sb.push_back(tbl[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard vec %0d: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk("rf_we",      i, 32'(rf_we_o),      32'(e.e_we));
        chk("rf_waddr",   i, 32'(rf_waddr_o),   32'(e.e_a));
        chk("rf_wdata",   i, rf_wdata_o,        e.e_d);
        chk("rf_src",     i, 32'(rf_src_o),     32'(e.e_src));
        chk("id_ready",   i, 32'(id_ready_o),   32'(e.e_idr));
        chk("lsu_ready",  i, 32'(lsu_ready_o),  32'(e.e_lr));
        chk("hazard",     i, 32'(hazard_o),     32'(e.e_hz));
        chk("fifo_count", i, 32'(fifo_count_o), 32'(e.e_cnt));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wr_arbiter.md
# ibex_rf_wr_arbiter

Arbiter and sequencer for the single register-file write port in the writeback stage. It shares the port between two requesters: the ID/EX result path (ALU, mult/div) and LSU load responses. LSU responses that lose arbitration are held in a small FIFO. A starvation counter guarantees LSU progress. The block also flags read-after-write and write-after-write hazards against buffered loads, so the ID stage can stall.

## Interface
Parameters:
- FifoDepth, 2 — LSU response buffer entries; power of two, 2..8.
- MaxStarve, 3 — cycles a buffered LSU entry may lose arbitration before forced priority; 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- id_we_i  in  1  ID/EX requests an RF write this cycle.
- id_waddr_i  in  5  ID/EX destination register.
- id_wdata_i  in  32  ID/EX write data.
- id_ready_o  out  1  ID/EX write accepted this cycle; ID stalls when low with id_we_i high.
- lsu_valid_i  in  1  LSU load response valid.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  32  load data.
- lsu_ready_o  out  1  LSU response accepted.
- rs1_addr_i, rs2_addr_i  in  5 each  ID source operands, used for hazard checks.
- hazard_o  out  1  an rs or id_waddr_i matches a buffered LSU entry.
- rf_we_o  out  1  RF write enable.
- rf_waddr_o  out  5  RF write address.
- rf_wdata_o  out  32  RF write data.
- rf_src_o  out  1  source of the current write: 0 = ID, 1 = LSU.
- fifo_count_o  out  $clog2(FifoDepth)+1  buffered entries.

## Operation
- FSM states: NORMAL and FORCE_LSU.
- **NORMAL:**
  - ID wins the port when id_we_i=1 and no WAW exists. A WAW exists when id_waddr_i matches any valid FIFO entry and id_waddr_i≠0.
  - Otherwise the FIFO head drains.
  - Otherwise an incoming LSU response is written through the bypass path (see Configuration).
- **FORCE_LSU:** the FIFO head drains unconditionally and id_ready_o=0. Next state is NORMAL.
- **Starvation counter:**
  - Resets to 0 on reset and on every head drain.
  - Increments each cycle the FIFO is non-empty and the head does not drain.
  - NORMAL→FORCE_LSU when the counter reaches MaxStarve and the head is still pending.
- id_ready_o is the ID grant. It is low during a WAW, in FORCE_LSU, and during reset.
- lsu_ready_o = !rst_i && (count<FifoDepth || head drains this cycle).
- A response with lsu_valid_i && lsu_ready_o that is not bypassed is pushed to the FIFO tail.
- A simultaneous push and pop keeps the count unchanged. FIFO pointers wrap modulo FifoDepth.
- **x0:** writes to register 0 are consumed normally (grant, push, pop) but force rf_we_o=0. x0 never raises hazard_o.
- hazard_o compares rs1, rs2 and id_waddr_i against all valid entries, excluding the entry popping this cycle.

## Timing
- Arbitration and RF outputs are combinational from the inputs and registered state.
- ID write latency is 0 cycles.
- LSU latency is 0 cycles with the bypass, otherwise ≥1 cycle.
- State (FIFO, pointers, count, counter, FSM) updates on the rising edge of clk_i.
- **Reset (rst_i high):**
  - Outputs: rf_we_o=0, id_ready_o=0, lsu_ready_o=0, hazard_o=0, fifo_count_o=0, rf_src_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - State after the edge: FIFO empty, counter 0, FSM NORMAL.
- Reset asserted mid-operation discards buffered entries.
- A full FIFO that pops in the same cycle accepts a push in that cycle.

## Configuration
- RF_ARB_BYPASS_EN defined: when the FIFO is empty and ID does not take the port, a valid LSU response writes the RF in the same cycle (rf_src_o=1) and is not pushed.
- Undefined: every LSU response passes through the FIFO, giving ≥1-cycle latency. The bypass mux is absent.

## Structure
- Package ibex_rf_arb_pkg holds:
  - enum wb_src_e {WB_SRC_ID, WB_SRC_LSU};
  - enum rf_arb_state_e {ARB_NORMAL, ARB_FORCE_LSU};
  - struct rf_wr_t {waddr[4:0], wdata[31:0]}.
- Sub-module ibex_rf_arb_fifo: parameterised FIFO of rf_wr_t with push, pop, count and per-entry valid/address visibility for hazard checks.

## Test plan
- Reset with id_we_i=1 and lsu_valid_i=1 → all outputs 0. After release, fifo_count_o=0.
- id_we_i=1 (x5, 0x1111) and lsu_valid_i=1 (x6, 0x2222) in the same cycle → rf_waddr_o=5. Next cycle rf_waddr_o=6, rf_wdata_o=0x2222, rf_src_o=1.
- LSU pushes x7 while ID writes every cycle, MaxStarve=3 → after 3 losing cycles FORCE_LSU writes x7, with id_ready_o=0 for exactly one cycle.
- FIFO holds x9, then id_we_i=1 with id_waddr_i=9 → id_ready_o=0 and hazard_o=1 until x9 drains. rs1_addr_i=9 also gives hazard_o=1.
- Fill FifoDepth=2 with ID continuously writing → lsu_ready_o=0. Then drop id_we_i with lsu_valid_i held → pop and push occur in the same cycle and the count stays at 2.
- LSU response to x0 with data 0xFFFF_FFFF → consumed, rf_we_o never 1, hazard_o=0. With the bypass enabled and idle, an LSU write to x3 has rf_we_o=1 in the same cycle.
